irq_priority_arbiter: RTL and testbench
=======================================

Name: irq_priority_arbiter

Overview:
- Sequential front end for the 8-to-3 priority encoder stage.
- Collects 8 interrupt/request lines into sticky pending bits and applies a per-line mask.
- Selects the highest-priority pending line (bit 7 highest, bit 0 lowest) and presents its 3-bit index on a valid/ready handshake.
- Clears the served pending bit on acceptance. Downstream consumers (interrupt controller, scheduler) take irq_id in place of a raw combinational encode.

Parameters:
- EDGE, 1, 1 = a pending bit sets on a 0->1 transition of req; 0 = a pending bit sets whenever req is high (level).
- N, 8, number of request lines. Fixed at 8; the index width is 3.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  grant enable; when low, no new grant is issued
- req  input  8  request lines, synchronous to clk
- mask  input  8  1 = line may be granted; 0 = line is held pending but not granted
- irq_valid  output  1  a granted index is presented
- irq_id  output  3  index of the granted line, stable while irq_valid=1
- irq_ready  input  1  consumer accepts irq_id when irq_valid & irq_ready
- pending  output  8  registered pending vector
- any_pending  output  1  OR-reduction of (pending & mask), registered-path combinational

Behaviour:
- Reset (rst_n=0, asynchronous): pending=0, req_q=0, irq_valid=0, irq_id=3'b000, FSM=IDLE. All outputs stay at these values until the first clk edge after rst_n deasserts.
- Set term per edge:
  - EDGE=1: set[i] = req[i] & ~req_q[i], with req_q <= req every cycle.
  - EDGE=0: set[i] = req[i].
  - Every edge: pending <= (pending & ~clr) | set.
- clr is one-hot on irq_id only during the accept cycle (irq_valid & irq_ready), otherwise 0.
- Simultaneous set and clr on the same bit: set wins, and the bit stays pending.
- Masked lines still accumulate in pending; they are granted once unmasked.
- FSM has two states, IDLE and PRESENT.
  - IDLE: if en=1 and (pending & mask) != 0, then irq_id <= index of the highest set bit of (pending & mask), irq_valid <= 1, and the FSM goes to PRESENT. Otherwise it stays in IDLE with irq_valid=0.
  - PRESENT: irq_valid=1 and irq_id are held constant regardless of en, mask or new req (no retraction, no pre-emption). On irq_ready=1: clear pending[irq_id], irq_valid <= 0, go to IDLE.
- Latency: req first sampled high at edge N -> pending bit set after edge N -> irq_valid=1 after edge N+1.
- Minimum spacing: after an accept there is one IDLE cycle before the next grant. Maximum throughput is one grant per 2 cycles.
- irq_ready while irq_valid=0 is ignored.
- en deasserted in IDLE blocks new grants only; pending keeps accumulating.
- Mask cleared on the presented line during PRESENT: the grant still completes and is still cleared on accept.
- Reset asserted mid-handshake: irq_valid drops immediately, and all pending requests are lost.

Test Plan:
- Reset check: rst_n=0 with req=8'hFF -> irq_valid=0, irq_id=0, pending=0. Release with mask=8'hFF, en=1 (EDGE=1, req already high, req_q=0 after reset) -> pending=8'hFF after first edge, irq_valid=1 with irq_id=7 after second edge.
- Priority order: pulse req=8'b0010_0100 for one cycle, mask=8'hFF, irq_ready=1 permanently -> grants irq_id=5, then irq_id=2 two cycles later, then pending=0 and irq_valid=0.
- Hold under stall: irq_id=2 presented with irq_ready=0 for 5 cycles, then req[6] pulses -> irq_id stays 2 and irq_valid stays 1. After irq_ready=1, the next grant is irq_id=6.
- Mask/enable: pending=8'b1000_0001 with mask=8'b0111_1111 -> grant irq_id=0 and bit 7 stays pending. Set en=0 then mask=8'hFF -> no grant while en=0. Set en=1 -> irq_id=7 one cycle later.
- Set/clear collision (EDGE=1): accept irq_id=3 in the same cycle req[3] rises again -> pending[3] remains 1 and irq_id=3 is re-granted after the idle cycle.
- EDGE=0: req[4] held high -> irq_id=4 is re-granted every 2 cycles while irq_ready=1. Asserting rst_n=0 mid-PRESENT -> irq_valid=0 asynchronously (before the next clk edge).

Source files
------------

// File: rtl/irq_priority_arbiter.sv
// Sticky-pending interrupt arbiter with a valid/ready grant handshake.
// Request lines set pending bits, either on a rising edge or while high.
// The highest-index pending line that is also unmasked is presented on irq_id.
// A presented grant is held until it is accepted, and acceptance clears that pending bit.
module irq_priority_arbiter #(
  parameter bit          EDGE = 1'b1,
  parameter int unsigned N    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         mask,
  output logic                 irq_valid,
  output logic [$clog2(N)-1:0] irq_id,
  input  logic                 irq_ready,
  output logic [N-1:0]         pending,
  output logic                 any_pending
);

  localparam int unsigned IdW = $clog2(N);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PRESENT = 1'b1;

  logic [0:0]     state_q, state_d;
  logic [N-1:0]   req_q;
  logic [N-1:0]   pending_q, pending_d;
  logic [IdW-1:0] irq_id_q, irq_id_d;
  logic [N-1:0]   set_vec;
  logic [N-1:0]   clr_vec;
  logic [N-1:0]   masked;
  logic           accept;

  // The highest set index wins; bit N-1 has top priority.
  function automatic logic [IdW-1:0] prio_enc(input logic [N-1:0] v);
    logic [IdW-1:0] idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = i[IdW-1:0];
    end
    return idx;
  endfunction

  assign masked      = pending_q & mask;
  assign any_pending = |masked;
  assign accept      = (state_q == ST_PRESENT) && irq_ready;

  // Set/clear terms. When set and clear hit the same bit, set wins, so a request that rises again during acceptance is kept.
  always_comb begin
    set_vec = EDGE ? (req & ~req_q) : req;
    clr_vec = '0;
    if (accept) clr_vec[irq_id_q] = 1'b1;
    pending_d = (pending_q & ~clr_vec) | set_vec;
  end

  // Grant FSM. A presented id stays frozen until it is accepted (no pre-emption).
  always_comb begin
    state_d  = state_q;
    irq_id_d = irq_id_q;
    unique case (state_q)
      ST_IDLE: begin
        if (en && any_pending) begin
          irq_id_d = prio_enc(masked);
          state_d  = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (irq_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers. Asynchronous reset discards all pending requests and any grant in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      pending_q <= '0;
      irq_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      req_q     <= req;
      pending_q <= pending_d;
      irq_id_q  <= irq_id_d;
    end
  end

  assign irq_valid = (state_q == ST_PRESENT);
  assign irq_id    = irq_id_q;
  assign pending   = pending_q;

endmodule

// File: tb/tb_irq_priority_arbiter.sv
// Directed bench: one edge-triggered instance and one level-triggered instance.
module tb_irq_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n, rst_nl;
  logic       en;
  logic [7:0] mask;
  logic [7:0] req, req_l;
  logic       ready, ready_l;
  logic       valid, valid_l;
  logic [2:0] id, id_l;
  logic [7:0] pend, pend_l;
  logic       anyp, anyp_l;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_priority_arbiter #(.EDGE(1'b1), .N(8)) u_edge (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mask(mask),
    .irq_valid(valid), .irq_id(id), .irq_ready(ready),
    .pending(pend), .any_pending(anyp)
  );

  irq_priority_arbiter #(.EDGE(1'b0), .N(8)) u_level (
    .clk(clk), .rst_n(rst_nl), .en(en), .req(req_l), .mask(mask),
    .irq_valid(valid_l), .irq_id(id_l), .irq_ready(ready_l),
    .pending(pend_l), .any_pending(anyp_l)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with all requests high.
    rst_n = 1'b0; rst_nl = 1'b0;
    en = 1'b1; mask = 8'hFF; req = 8'hFF; ready = 1'b0;
    req_l = 8'h00; ready_l = 1'b0;
    #12;
    chk("rst_valid", {7'd0, valid}, 8'd0);
    chk("rst_id", {5'd0, id}, 8'd0);
    chk("rst_pend", pend, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("rel_pend", pend, 8'hFF);
    chk("rel_valid0", {7'd0, valid}, 8'd0);
    tick();
    chk("rel_valid1", {7'd0, valid}, 8'd1);
    chk("rel_id7", {5'd0, id}, 8'd7);

    // Clear for the next scenario.
    req = 8'h00; rst_n = 1'b0; #2; rst_n = 1'b1;

    // Priority order with a one-cycle pulse, ready held high.
    ready = 1'b1; req = 8'b0010_0100;
    tick(); req = 8'h00;
    chk("pri_pend", pend, 8'h24);
    chk("pri_v0", {7'd0, valid}, 8'd0);
    tick();
    chk("pri_v5", {7'd0, valid}, 8'd1);
    chk("pri_id5", {5'd0, id}, 8'd5);
    tick();
    chk("pri_idle", {7'd0, valid}, 8'd0);
    chk("pri_pend2", pend, 8'h04);
    tick();
    chk("pri_v2", {7'd0, valid}, 8'd1);
    chk("pri_id2", {5'd0, id}, 8'd2);
    tick();
    chk("pri_done_v", {7'd0, valid}, 8'd0);
    chk("pri_done_p", pend, 8'h00);
    tick();
    chk("pri_quiet", {7'd0, valid}, 8'd0);

    // Grant held under stall while a higher-priority line arrives.
    ready = 1'b0; req = 8'h04;
    tick(); req = 8'h00;
    tick();
    chk("hold_id2", {5'd0, id}, 8'd2);
    req = 8'h40;
    tick(); req = 8'h00;
    chk("hold_pend", pend, 8'h44);
    for (int i = 0; i < 4; i++) tick();
    chk("hold_v", {7'd0, valid}, 8'd1);
    chk("hold_id", {5'd0, id}, 8'd2);
    ready = 1'b1;
    tick();
    chk("hold_acc_v", {7'd0, valid}, 8'd0);
    chk("hold_acc_p", pend, 8'h40);
    tick();
    chk("hold_id6", {5'd0, id}, 8'd6);
    chk("hold_v6", {7'd0, valid}, 8'd1);
    tick();
    chk("hold_empty", pend, 8'h00);

    // Mask and enable.
    ready = 1'b0; mask = 8'h7F; req = 8'h81;
    tick(); req = 8'h00;
    chk("msk_any", {7'd0, anyp}, 8'd1);
    tick();
    chk("msk_id0", {5'd0, id}, 8'd0);
    chk("msk_v", {7'd0, valid}, 8'd1);
    ready = 1'b1;
    tick();
    chk("msk_pend", pend, 8'h80);
    chk("msk_any0", {7'd0, anyp}, 8'd0);
    en = 1'b0;
    tick();
    chk("msk_novalid", {7'd0, valid}, 8'd0);
    mask = 8'hFF;
    tick();
    chk("en0_v", {7'd0, valid}, 8'd0);
    chk("en0_any", {7'd0, anyp}, 8'd1);
    tick();
    chk("en0_v2", {7'd0, valid}, 8'd0);
    en = 1'b1;
    tick();
    chk("en1_v", {7'd0, valid}, 8'd1);
    chk("en1_id7", {5'd0, id}, 8'd7);
    tick();
    chk("en1_clr", pend, 8'h00);

    // Set/clear collision on bit 3.
    ready = 1'b0; req = 8'h08;
    tick(); req = 8'h00;
    tick();
    chk("col_id3", {5'd0, id}, 8'd3);
    ready = 1'b1; req = 8'h08;
    tick(); req = 8'h00;
    chk("col_pend", pend, 8'h08);
    chk("col_v0", {7'd0, valid}, 8'd0);
    tick();
    chk("col_regrant_v", {7'd0, valid}, 8'd1);
    chk("col_regrant_id", {5'd0, id}, 8'd3);
    tick();
    chk("col_final", pend, 8'h00);

    // Level mode: a held request is re-granted every two cycles.
    rst_nl = 1'b1; req_l = 8'h10; ready_l = 1'b1;
    tick();
    chk("lvl_pend", pend_l, 8'h10);
    chk("lvl_v0", {7'd0, valid_l}, 8'd0);
    tick();
    chk("lvl_v1", {7'd0, valid_l}, 8'd1);
    chk("lvl_id4", {5'd0, id_l}, 8'd4);
    tick();
    chk("lvl_acc_v", {7'd0, valid_l}, 8'd0);
    chk("lvl_acc_p", pend_l, 8'h10);
    tick();
    chk("lvl_v2", {7'd0, valid_l}, 8'd1);
    chk("lvl_id4b", {5'd0, id_l}, 8'd4);
    // Asynchronous reset while presenting.
    rst_nl = 1'b0;
    #1;
    chk("async_v", {7'd0, valid_l}, 8'd0);
    chk("async_p", pend_l, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
